// File: rtl/pktgen_flow_scheduler.sv
// Token-bucket credit scheduler with round-robin arbitration for the multi-flow packet generator.
// One grant is outstanding at a time: offered, accepted, then held until pkt_done.
module pktgen_flow_scheduler #(
    parameter int unsigned           N_FLOWS  = 4,
    parameter int unsigned           FRAC_W   = 16,
    parameter int unsigned           CREDIT_W = 32,
    parameter logic [N_FLOWS*32-1:0] RATES    = {N_FLOWS{32'h0001_0000}},
    parameter logic [N_FLOWS*11-1:0] SIZES    = {N_FLOWS{11'd192}},
    parameter int unsigned           CAP      = 4096
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             enable,
    output logic                                             grant_valid,
    input  logic                                             grant_ready,
    output logic [((N_FLOWS > 1) ? $clog2(N_FLOWS) : 1)-1:0] grant_flow,
    output logic [10:0]                                      grant_size,
    input  logic                                             pkt_done,
    output logic [N_FLOWS-1:0]                               credit_sat,
    output logic [31:0]                                      grant_count
);

    localparam int unsigned      IDX_W  = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1;
    localparam int unsigned      CW1    = CREDIT_W + 1;
    localparam logic [CREDIT_W:0] CAP_FX = CW1'(CAP) << FRAC_W;

    typedef enum logic [1:0] {IDLE, OFFER, WAIT} state_t;

    state_t               state, state_nxt;
    logic [CREDIT_W-1:0]  credit     [N_FLOWS];
    logic [CREDIT_W:0]    credit_sum [N_FLOWS];
    logic [CREDIT_W-1:0]  credit_nxt [N_FLOWS];
    logic [N_FLOWS-1:0]   eligible;
    logic [IDX_W-1:0]     rr_ptr, winner, win_hi, win_lo;
    logic                 found_hi, found_lo;
    logic                 launch, handshake;

    function automatic logic [CREDIT_W:0] size_fx(input int unsigned i);
        return CW1'(SIZES[i*11 +: 11]) << FRAC_W;
    endfunction

    function automatic logic [CREDIT_W:0] rate_w(input int unsigned i);
        return CW1'(RATES[i*32 +: 32]);
    endfunction

    assign handshake = grant_valid & grant_ready;
    assign launch    = (state == IDLE) && enable && found_lo;

    always_comb begin
        for (int unsigned i = 0; i < N_FLOWS; i++) begin
            eligible[i]   = {1'b0, credit[i]} >= size_fx(i);
            credit_sum[i] = {1'b0, credit[i]} + (enable ? rate_w(i) : '0);
            if (handshake && (32'(grant_flow) == i))
                credit_sum[i] = credit_sum[i] - size_fx(i);
            credit_nxt[i] = (credit_sum[i] > CAP_FX) ? CAP_FX[CREDIT_W-1:0]
                                                     : credit_sum[i][CREDIT_W-1:0];
        end
    end

    // Two scans: first eligible at or above rr_ptr, else first eligible overall (wrap).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int unsigned j = 0; j < N_FLOWS; j++) begin
            if (eligible[j] && !found_lo) begin
                win_lo   = IDX_W'(j);
                found_lo = 1'b1;
            end
            if (eligible[j] && !found_hi && (j >= 32'(rr_ptr))) begin
                win_hi   = IDX_W'(j);
                found_hi = 1'b1;
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch)      state_nxt = OFFER;
            OFFER:   if (grant_ready) state_nxt = WAIT;
            WAIT:    if (pkt_done)    state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_valid = (state == OFFER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_FLOWS; i++) credit[i] <= '0;
            credit_sat  <= '0;
            rr_ptr      <= '0;
            grant_flow  <= '0;
            grant_size  <= '0;
            grant_count <= '0;
        end else begin
            for (int unsigned i = 0; i < N_FLOWS; i++) begin
                credit[i]     <= credit_nxt[i];
                credit_sat[i] <= (credit_nxt[i] == CAP_FX[CREDIT_W-1:0]);
            end
            if (launch) begin
                grant_flow <= winner;
                grant_size <= SIZES[32'(winner)*11 +: 11];
            end
            if (handshake) begin
                rr_ptr      <= (32'(grant_flow) == N_FLOWS - 1) ? '0 : grant_flow + IDX_W'(1);
                grant_count <= grant_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pktgen_flow_scheduler.sv
// Self-checking bench for pktgen_flow_scheduler: directed timing cases over several
// configurations plus a randomized run against a behavioural credit/arbiter model.
module tb_pktgen_flow_scheduler;

    localparam longint FX = 65536;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // u1: single flow, 1 byte/cycle, 64-byte frames
    logic en1, rdy1, done1, gv1;
    logic [0:0] gf1, sat1;
    logic [10:0] gs1;
    logic [31:0] gc1;
    // u4: four flows, 256 bytes/cycle, 64-byte frames
    logic en4, rdy4, done4, gv4;
    logic [1:0] gf4;
    logic [10:0] gs4;
    logic [3:0] sat4;
    logic [31:0] gc4;
    // ub: only flows 1 and 3 accrue
    logic enb, rdyb, doneb, gvb;
    logic [1:0] gfb;
    logic [10:0] gsb;
    logic [3:0] satb;
    logic [31:0] gcb;
    // us: 16 bytes/cycle, 192-byte frames, saturation
    logic ens, rdys, dones, gvs;
    logic [1:0] gfs;
    logic [10:0] gss;
    logic [3:0] sats;
    logic [31:0] gcs;
    // ur: mixed fractional rates and sizes, randomized
    logic enr, rdyr, doner, gvr;
    logic [1:0] gfr;
    logic [10:0] gsr;
    logic [3:0] satr;
    logic [31:0] gcr;

    pktgen_flow_scheduler #(.N_FLOWS(1), .FRAC_W(16), .CREDIT_W(32),
        .RATES(32'h0001_0000), .SIZES(11'd64), .CAP(4096)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .grant_valid(gv1), .grant_ready(rdy1),
        .grant_flow(gf1), .grant_size(gs1), .pkt_done(done1), .credit_sat(sat1), .grant_count(gc1));

    pktgen_flow_scheduler #(.N_FLOWS(4), .FRAC_W(16), .CREDIT_W(32),
        .RATES({4{32'h0100_0000}}), .SIZES({4{11'd64}}), .CAP(4096)) u4 (
        .clk(clk), .rst_n(rst_n), .enable(en4), .grant_valid(gv4), .grant_ready(rdy4),
        .grant_flow(gf4), .grant_size(gs4), .pkt_done(done4), .credit_sat(sat4), .grant_count(gc4));

    pktgen_flow_scheduler #(.N_FLOWS(4), .FRAC_W(16), .CREDIT_W(32),
        .RATES({32'h0010_0000, 32'h0, 32'h0010_0000, 32'h0}), .SIZES({4{11'd64}}), .CAP(4096)) ub (
        .clk(clk), .rst_n(rst_n), .enable(enb), .grant_valid(gvb), .grant_ready(rdyb),
        .grant_flow(gfb), .grant_size(gsb), .pkt_done(doneb), .credit_sat(satb), .grant_count(gcb));

    pktgen_flow_scheduler #(.N_FLOWS(4), .FRAC_W(16), .CREDIT_W(32),
        .RATES({4{32'h0010_0000}}), .SIZES({4{11'd192}}), .CAP(4096)) us (
        .clk(clk), .rst_n(rst_n), .enable(ens), .grant_valid(gvs), .grant_ready(rdys),
        .grant_flow(gfs), .grant_size(gss), .pkt_done(dones), .credit_sat(sats), .grant_count(gcs));

    pktgen_flow_scheduler #(.N_FLOWS(4), .FRAC_W(16), .CREDIT_W(32),
        .RATES({32'h0001_4000, 32'h0008_0000, 32'h0000_C000, 32'h0003_8000}),
        .SIZES({11'd77, 11'd300, 11'd64, 11'd100}), .CAP(512)) ur (
        .clk(clk), .rst_n(rst_n), .enable(enr), .grant_valid(gvr), .grant_ready(rdyr),
        .grant_flow(gfr), .grant_size(gsr), .pkt_done(doner), .credit_sat(satr), .grant_count(gcr));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        {en1, rdy1, done1, en4, rdy4, done4, enb, rdyb, doneb,
         ens, rdys, dones, enr, rdyr, doner} = 15'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Edges after reset release until u1 first offers a grant (-1 if none).
    task automatic wait_first_valid1(output int first_e);
        int e = 0;
        first_e = -1;
        while (first_e < 0 && e < 200) begin
            @(negedge clk);
            e++;
            if (gv1) first_e = e;
        end
    endtask

    task automatic peek(input int sel, output int v, output int fl, output int sz, output int cnt);
        if (sel == 4) begin
            v = int'(gv4); fl = int'(gf4); sz = int'(gs4); cnt = int'(gc4);
        end else begin
            v = int'(gvb); fl = int'(gfb); sz = int'(gsb); cnt = int'(gcb);
        end
    endtask

    task automatic set_done(input int sel, input logic b);
        if (sel == 4) done4 = b;
        else          doneb = b;
    endtask

    // Wait for an offer, let it be accepted (ready held high), pulse pkt_done dly cycles later.
    task automatic grant_cycle(input int sel, input int dly, output int fl, output int sz,
                               output int cnt, output int v_acc, output int v_m, output int v_m1);
        int w = 0;
        int v, f2, s2;
        peek(sel, v, fl, sz, cnt);
        while (v == 0 && w < 500) begin
            @(negedge clk);
            w++;
            peek(sel, v, fl, sz, cnt);
        end
        if (v == 0) fl = -1;
        @(negedge clk);
        peek(sel, v_acc, f2, s2, cnt);
        repeat (dly - 1) @(negedge clk);
        set_done(sel, 1'b1);
        @(negedge clk);
        set_done(sel, 1'b0);
        peek(sel, v_m, f2, s2, w);
        @(negedge clk);
        peek(sel, v_m1, f2, s2, w);
    endtask

    // Behavioural model of the mixed-rate configuration.
    longint m_rate [4] = '{64'h0003_8000, 64'h0000_C000, 64'h0008_0000, 64'h0001_4000};
    longint m_size [4] = '{100, 64, 300, 77};
    localparam longint M_CAP = 512;
    longint m_credit [4];
    bit     m_offer, m_busy;
    int     m_flow, m_ptr, m_gsize;
    longint m_count;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_credit[i] = 0;
        m_offer = 0; m_busy = 0; m_flow = 0; m_ptr = 0; m_gsize = 0; m_count = 0;
    endtask

    task automatic model_step(input bit en, input bit rdy, input bit done);
        longint nc [4];
        bit accept, found;
        accept = m_offer && rdy;
        for (int i = 0; i < 4; i++) begin
            nc[i] = m_credit[i] + (en ? m_rate[i] : 0);
            if (accept && i == m_flow) nc[i] = nc[i] - m_size[i] * FX;
            if (nc[i] > M_CAP * FX) nc[i] = M_CAP * FX;
        end
        if (m_offer) begin
            if (rdy) begin
                m_offer = 0;
                m_busy  = 1;
                m_ptr   = (m_flow + 1) % 4;
                m_count = (m_count + 1) % (64'd1 << 32);
            end
        end else if (m_busy) begin
            if (done) m_busy = 0;
        end else if (en) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                int f;
                f = (m_ptr + k) % 4;
                if (!found && m_credit[f] >= m_size[f] * FX) begin
                    found   = 1;
                    m_offer = 1;
                    m_flow  = f;
                    m_gsize = int'(m_size[f]);
                end
            end
        end
        for (int i = 0; i < 4; i++) m_credit[i] = nc[i];
    endtask

    typedef struct {
        int sel;
        int done_dly;
        int exp_flow;
        int exp_size;
        int exp_count;
    } vec_t;

    initial begin
        vec_t tbl [10];
        int first_e, e, na, prev, stable, sat_first, first_gv, ok;
        int acc [5];
        int fl, sz, cnt, v_acc, v_m, v_m1;
        logic [49:0] actv, expv;
        logic [3:0] msat;
        bit ren, rrdy, rdone;

        tbl[0] = '{4, 2, 0, 64, 1};
        tbl[1] = '{4, 2, 1, 64, 2};
        tbl[2] = '{4, 2, 2, 64, 3};
        tbl[3] = '{4, 2, 3, 64, 4};
        tbl[4] = '{4, 2, 0, 64, 5};
        tbl[5] = '{4, 2, 1, 64, 6};
        tbl[6] = '{13, 2, 1, 64, 1};
        tbl[7] = '{13, 2, 3, 64, 2};
        tbl[8] = '{13, 2, 1, 64, 3};
        tbl[9] = '{13, 2, 3, 64, 4};

        // Reset state
        do_reset();
        check("reset_u1", 64'({gv1, gf1, gs1, sat1, gc1}), 64'(0));
        check("reset_u4", 64'({gv4, gf4, gs4, sat4, gc4}), 64'(0));

        // Single flow: first grant timing, post-accept credit, steady-state period
        en1 = 1'b1; rdy1 = 1'b1;
        wait_first_valid1(first_e);
        check("c1_first_valid_edge", 64'(first_e), 64'(65));
        check("c1_grant_size", 64'(gs1), 64'(64));
        check("c1_grant_flow", 64'(gf1), 64'(0));
        e = first_e; na = 0; prev = int'(gc1);
        for (int i = 0; i < 5; i++) acc[i] = 0;
        while (na < 5 && e < 700) begin
            @(negedge clk);
            e++;
            done1 = 1'b0;
            if (int'(gc1) != prev) begin
                acc[na] = e;
                prev = int'(gc1);
                if (na == 0) begin
                    check("c1_credit_after_accept", 64'(u1.credit[0] >> 16), 64'(2));
                    check("c1_valid_drops", 64'(gv1), 64'(0));
                end
                na++;
                done1 = 1'b1;
            end
        end
        done1 = 1'b0;
        check("c1_accept_count", 64'(na), 64'(5));
        check("c1_first_accept_edge", 64'(acc[0]), 64'(66));
        check("c1_avg_period", 64'((acc[4] - acc[0]) / 4), 64'(64));

        // Reset pulsed while waiting for pkt_done
        do_reset();
        en1 = 1'b1; rdy1 = 1'b1;
        e = 0;
        while (gc1 != 32'd1 && e < 200) begin
            @(negedge clk);
            e++;
        end
        check("rst_pre_count", 64'(gc1), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_count", 64'(gc1), 64'(0));
        check("rst_async_valid", 64'(gv1), 64'(0));
        check("rst_async_sat", 64'(sat1), 64'(0));
        check("rst_async_size", 64'(gs1), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        wait_first_valid1(first_e);
        check("rst_first_valid_edge", 64'(first_e), 64'(65));

        // Round-robin sequences
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].exp_count == 1) begin
                do_reset();
                if (tbl[i].sel == 4) begin en4 = 1'b1; rdy4 = 1'b1; end
                else                 begin enb = 1'b1; rdyb = 1'b1; end
            end
            grant_cycle(tbl[i].sel, tbl[i].done_dly, fl, sz, cnt, v_acc, v_m, v_m1);
            check($sformatf("rr%0d_%0d_flow", tbl[i].sel, i), 64'(fl), 64'(tbl[i].exp_flow));
            check($sformatf("rr%0d_%0d_size", tbl[i].sel, i), 64'(sz), 64'(tbl[i].exp_size));
            check($sformatf("rr%0d_%0d_count", tbl[i].sel, i), 64'(cnt), 64'(tbl[i].exp_count));
            check($sformatf("rr%0d_%0d_valid_after_accept", tbl[i].sel, i), 64'(v_acc), 64'(0));
            check($sformatf("rr%0d_%0d_valid_at_done", tbl[i].sel, i), 64'(v_m), 64'(0));
            check($sformatf("rr%0d_%0d_valid_done_plus1", tbl[i].sel, i), 64'(v_m1), 64'(1));
        end

        // Saturation while the first grant is held unaccepted
        do_reset();
        ens = 1'b1; rdys = 1'b0;
        stable = 1; sat_first = -1; first_gv = -1;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (sat_first < 0 && sats == 4'hF) sat_first = k;
            if (first_gv < 0 && gvs) first_gv = k;
            if (k >= 13 && !(gvs && gfs == 2'd0 && gss == 11'd192)) stable = 0;
        end
        check("sat_first_offer_edge", 64'(first_gv), 64'(13));
        check("sat_first_edge", 64'(sat_first), 64'(256));
        check("sat_grant_held_stable", 64'(stable), 64'(1));
        rdys = 1'b1;
        @(negedge clk);
        rdys = 1'b0;
        check("sat_accept_count", 64'(gcs), 64'(1));
        check("sat_after_accept", 64'(sats), 64'(4'hE));
        repeat (10) @(negedge clk);
        check("sat_refill_pending", 64'(sats), 64'(4'hE));
        @(negedge clk);
        check("sat_refilled", 64'(sats), 64'(4'hF));

        // enable dropped while a grant is offered
        do_reset();
        en4 = 1'b1; rdy4 = 1'b0;
        repeat (30) @(negedge clk);
        check("en_offer_before_drop", 64'(gv4), 64'(1));
        check("en_sat_before_drop", 64'(sats == sats ? sat4 : sat4), 64'(4'hF));
        en4 = 1'b0;
        repeat (3) @(negedge clk);
        check("en_offer_held", 64'(gv4), 64'(1));
        rdy4 = 1'b1;
        @(negedge clk);
        rdy4 = 1'b0;
        check("en_accept_count", 64'(gc4), 64'(1));
        done4 = 1'b1;
        @(negedge clk);
        done4 = 1'b0;
        ok = 1;
        repeat (20) begin
            @(negedge clk);
            if (gv4 || sat4 != 4'hE || gc4 != 32'd1) ok = 0;
        end
        check("en_low_no_grant_credit_hold", 64'(ok), 64'(1));
        check("en_low_flow0_credit", 64'(u4.credit[0] >> 16), 64'(4032));

        // Randomized run against the behavioural model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) msat[i] = (m_credit[i] == M_CAP * FX);
            expv = {m_offer, 2'(m_flow), 11'(m_gsize), msat, 32'(m_count)};
            actv = {gvr, gfr, gsr, satr, gcr};
            check($sformatf("rand_cycle_%0d", c), 64'(actv), 64'(expv));
            ren   = ($urandom_range(0, 9) < 8);
            rrdy  = ($urandom_range(0, 1) == 1);
            rdone = ($urandom_range(0, 3) == 0);
            enr = ren; rdyr = rrdy; doner = rdone;
            model_step(ren, rrdy, rdone);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
